// File: rtl/regfile_port_arbiter.sv
// Arbitrates one writeback port and two operand-read ports onto a single-port register file.
// Writes take priority. Reads alternate round-robin, and a read can preempt a persistent write stream.
module regfile_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int REG_BITS     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [REG_BITS-1:0] i_wr_addr,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic                i_rd0_valid,
  output logic                o_rd0_ready,
  input  logic [REG_BITS-1:0] i_rd0_addr,
  output logic                o_rd0_rsp_valid,
  output logic [XLEN-1:0]     o_rd0_rsp_data,
  input  logic                i_rd1_valid,
  output logic                o_rd1_ready,
  input  logic [REG_BITS-1:0] i_rd1_addr,
  output logic                o_rd1_rsp_valid,
  output logic [XLEN-1:0]     o_rd1_rsp_data,
  output logic [REG_BITS-1:0] o_rf_reg_num,
  output logic                o_rf_write,
  output logic [XLEN-1:0]     o_rf_data_in,
  input  logic [XLEN-1:0]     i_rf_data_out
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             r_rr_ptr;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;

  logic                w_any_rd;
  logic                w_sel_rd1;
  logic [REG_BITS-1:0] w_sel_addr;
  logic                w_starve;
  logic                w_override_ok;
  logic                w_wr_wins;
  logic                w_grant_wr;
  logic                w_grant_rd;
  logic                w_grant_rd0;
  logic                w_grant_rd1;

  assign w_any_rd   = i_rd0_valid | i_rd1_valid;
  assign w_sel_rd1  = i_rd1_valid & (~i_rd0_valid | r_rr_ptr);
  assign w_sel_addr = w_sel_rd1 ? i_rd1_addr : i_rd0_addr;
  assign w_starve   = (r_starve_cnt == CNT_MAX) & w_any_rd;

  // A read never overtakes a pending write to the same live register.
  assign w_override_ok = (w_sel_addr != i_wr_addr) | (i_wr_addr == '0);
  assign w_wr_wins     = i_wr_valid & ~(w_starve & w_override_ok);

  assign w_grant_wr  = i_rst_n & w_wr_wins;
  assign w_grant_rd  = i_rst_n & ~w_wr_wins & w_any_rd;
  assign w_grant_rd0 = w_grant_rd & ~w_sel_rd1;
  assign w_grant_rd1 = w_grant_rd & w_sel_rd1;

  assign o_wr_ready  = w_grant_wr;
  assign o_rd0_ready = w_grant_rd0;
  assign o_rd1_ready = w_grant_rd1;

  assign o_rf_write   = w_grant_wr;
  assign o_rf_data_in = i_wr_data;

  always_comb begin
    o_rf_reg_num = '0;
    if (w_grant_wr) begin
      o_rf_reg_num = i_wr_addr;
    end else if (w_grant_rd) begin
      o_rf_reg_num = w_sel_addr;
    end
  end

  // Gating with reset drops a response whose grant landed just before reset asserted.
  assign o_rd0_rsp_valid = r_rsp0_valid & i_rst_n;
  assign o_rd1_rsp_valid = r_rsp1_valid & i_rst_n;
  assign o_rd0_rsp_data  = i_rf_data_out;
  assign o_rd1_rsp_data  = i_rf_data_out;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= 1'b0;
      r_starve_cnt <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= w_grant_rd0;
      r_rsp1_valid <= w_grant_rd1;
      if (w_grant_rd) begin
        r_rr_ptr <= ~w_sel_rd1;
      end
      if (w_grant_rd) begin
        r_starve_cnt <= '0;
      end else if (w_grant_wr && w_any_rd) begin
        if (r_starve_cnt != CNT_MAX) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed-vector bench with a register-file model; the stimulus queues the expected grants and responses.
// A monitor process pops and compares them whenever the arbiter grants a port or presents read data.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0, rd0_valid = 1'b0, rd1_valid = 1'b0;
  logic [4:0]  wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
  logic [63:0] wr_data = '0;
  logic        wr_ready, rd0_ready, rd1_ready;
  logic        rd0_rsp_valid, rd1_rsp_valid;
  logic [63:0] rd0_rsp_data, rd1_rsp_data;
  logic [4:0]  rf_reg_num;
  logic        rf_write;
  logic [63:0] rf_data_in;
  logic [63:0] rf_data_out = '0;
  logic [63:0] mem [32] = '{default: 64'h0};

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0]  q_grant [$];
  logic [63:0] q_rsp0 [$];
  logic [63:0] q_rsp1 [$];

  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd0_valid(rd0_valid), .o_rd0_ready(rd0_ready), .i_rd0_addr(rd0_addr),
    .o_rd0_rsp_valid(rd0_rsp_valid), .o_rd0_rsp_data(rd0_rsp_data),
    .i_rd1_valid(rd1_valid), .o_rd1_ready(rd1_ready), .i_rd1_addr(rd1_addr),
    .o_rd1_rsp_valid(rd1_rsp_valid), .o_rd1_rsp_data(rd1_rsp_data),
    .o_rf_reg_num(rf_reg_num), .o_rf_write(rf_write), .o_rf_data_in(rf_data_in),
    .i_rf_data_out(rf_data_out)
  );

  // Register file: registered read port, x0 hardwired to zero.
  always @(posedge clk) begin
    if (rf_write && rf_reg_num != 5'd0) mem[rf_reg_num] <= rf_data_in;
    rf_data_out <= (rf_reg_num == 5'd0) ? 64'h0 : mem[rf_reg_num];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: grant code 1=write, 2=rd0, 3=rd1.
  initial begin
    logic [1:0]  code;
    logic [6:0]  e;
    logic [63:0] d;
    forever begin
      @(negedge clk);
      if (int'(wr_ready) + int'(rd0_ready) + int'(rd1_ready) > 1)
        chk("ready_onehot", {61'b0, wr_ready, rd0_ready, rd1_ready}, 64'h0);
      code = wr_ready ? 2'd1 : rd0_ready ? 2'd2 : rd1_ready ? 2'd3 : 2'd0;
      if (code != 2'd0) begin
        if (q_grant.size() == 0) begin
          chk("grant_unexpected", {56'b0, code, rf_reg_num, rf_write}, 64'h0);
        end else begin
          e = q_grant.pop_front();
          chk("grant", {56'b0, code, rf_reg_num, rf_write},
              {56'b0, e, (e[6:5] == 2'd1)});
        end
      end else begin
        chk("idle_port", {58'b0, rf_write, rf_reg_num}, 64'h0);
      end
      if (rd0_rsp_valid) begin
        if (q_rsp0.size() == 0) chk("rsp0_unexpected", 64'h1, 64'h0);
        else begin d = q_rsp0.pop_front(); chk("rsp0_data", rd0_rsp_data, d); end
      end
      if (rd1_rsp_valid) begin
        if (q_rsp1.size() == 0) chk("rsp1_unexpected", 64'h1, 64'h0);
        else begin d = q_rsp1.pop_front(); chk("rsp1_data", rd1_rsp_data, d); end
      end
    end
  end

  // One cycle of stimulus; eg/ega = expected grant code and register, er/ed = expected response.
  task automatic step(input logic rst, input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                      input logic r0v, input logic [4:0] r0a, input logic r1v, input logic [4:0] r1a,
                      input logic [1:0] eg, input logic [4:0] ega, input logic er, input logic [63:0] ed);
    rst_n = rst;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd0_valid = r0v; rd0_addr = r0a;
    rd1_valid = r1v; rd1_addr = r1a;
    if (eg != 2'd0) q_grant.push_back({eg, ega});
    if (er && eg == 2'd2) q_rsp0.push_back(ed);
    if (er && eg == 2'd3) q_rsp1.push_back(ed);
    if (!rst) begin
      @(negedge clk);
      chk("reset_outputs", {58'b0, wr_ready, rd0_ready, rd1_ready, rf_write, rd0_rsp_valid, rd1_rsp_valid},
          64'h0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset with every requester active, then write wins first.
    for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 64'h11, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0);
    step(1, 1, 5'd1, 64'h11, 1, 5'd2, 1, 5'd3, 1, 5'd1, 0, 0);
    step(1, 0, 5'd0, 64'h0,  1, 5'd2, 1, 5'd3, 2, 5'd2, 1, 64'h0);
    step(1, 0, 5'd0, 64'h0,  0, 5'd0, 1, 5'd3, 3, 5'd3, 1, 64'h0);
    // Write then immediate read of the same register.
    step(1, 1, 5'd3, 64'h3333,     0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 0);
    step(1, 1, 5'd5, 64'hDEADBEEF, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 0);
    step(1, 0, 5'd0, 64'h0,        1, 5'd5, 0, 5'd0, 2, 5'd5, 1, 64'hDEADBEEF);
    step(1, 0, 5'd0, 64'h0,        0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    // x0 write is granted but discarded.
    step(1, 1, 5'd0, 64'h1234, 0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0);
    step(1, 0, 5'd0, 64'h0,    0, 5'd0, 1, 5'd0, 3, 5'd0, 1, 64'h0);
    step(1, 0, 5'd0, 64'h0,    0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    // Starvation guard: four write wins, then the read to a different register.
    for (int i = 0; i < 4; i++) step(1, 1, 5'd7, 64'h77, 1, 5'd3, 0, 5'd0, 1, 5'd7, 0, 0);
    step(1, 1, 5'd7, 64'h77, 1, 5'd3, 0, 5'd0, 2, 5'd3, 1, 64'h3333);
    step(1, 1, 5'd7, 64'h77, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0);
    // Same-register read is never promoted over the write stream.
    for (int i = 0; i < 8; i++) step(1, 1, 5'd7, 64'h7777, 1, 5'd7, 0, 5'd0, 1, 5'd7, 0, 0);
    step(1, 0, 5'd0, 64'h0, 1, 5'd7, 0, 5'd0, 2, 5'd7, 1, 64'h7777);
    // Reset right after an rd1 grant suppresses its response.
    step(1, 0, 5'd0, 64'h0, 0, 5'd0, 1, 5'd5, 3, 5'd5, 0, 0);
    step(0, 0, 5'd0, 64'h0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    step(0, 0, 5'd0, 64'h0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    // Round-robin from a fresh pointer.
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 5'd0, 64'h0, 1, 5'd1, 1, 5'd5, 2, 5'd1, 1, 64'h11);
      step(1, 0, 5'd0, 64'h0, 1, 5'd1, 1, 5'd5, 3, 5'd5, 1, 64'hDEADBEEF);
    end
    // A write stream to x0 does not block a starving x0 read.
    for (int i = 0; i < 4; i++) step(1, 1, 5'd0, 64'h5, 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
    step(1, 1, 5'd0, 64'h5, 0, 5'd0, 1, 5'd0, 3, 5'd0, 1, 64'h0);
    step(1, 0, 5'd0, 64'h0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    step(1, 0, 5'd0, 64'h0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    chk("grants_left", 64'(q_grant.size()), 64'h0);
    chk("rsp0_left",   64'(q_rsp0.size()),  64'h0);
    chk("rsp1_left",   64'(q_rsp1.size()),  64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
